proc_mngr_port: RTL and testbench

Processor-side endpoint of the test-manager channel pair. It terminates the 32-bit val/rdy streams mngr2proc (manager to processor) and proc2mngr (processor to manager), and exposes them to the core's X-stage CSR logic. `csrr mngr2proc` pops a buffered inbound message. `csrw proc2mngr` pushes an outbound message. The core stalls when the inbound buffer is empty or the outbound buffer is full. It sits between the core datapath and the bench's manager interface.

---
 rtl/proc_mngr_port.sv | 138 +++++++++++++
 tb/tb_proc_mngr_port.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/proc_mngr_port.sv
// proc_mngr_port: processor-side endpoint of the manager channel pair.
// Inbound messages (mngr2proc) are buffered in a small FIFO and popped by a
// csrr of CSR_MNGR2PROC. Outbound messages are pushed into a second FIFO by a
// csrw of CSR_PROC2MNGR and drained over proc2mngr.
// Optional build macro: PROC_MNGR_STATS_EN adds the rx_count/tx_count
// handshake counters and their ports.
module proc_mngr_port #(
  parameter int          DEPTH         = 2,
  parameter logic [11:0] CSR_MNGR2PROC = 12'hFC0,
  parameter logic [11:0] CSR_PROC2MNGR = 12'h7C0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mngr2proc_val,
  output logic        mngr2proc_rdy,
  input  logic [31:0] mngr2proc_msg,
  output logic        proc2mngr_val,
  input  logic        proc2mngr_rdy,
  output logic [31:0] proc2mngr_msg,
  input  logic        csr_req_val,
  input  logic        csr_req_wen,
  input  logic [11:0] csr_req_addr,
  input  logic [31:0] csr_req_wdata,
  output logic        csr_req_stall,
  output logic [31:0] csr_resp_rdata,
  output logic        csr_req_illegal
`ifdef PROC_MNGR_STATS_EN
  ,
  output logic [15:0] rx_count,
  output logic [15:0] tx_count
`endif
);

  localparam int         AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW + 1)'(1);

  // Inbound FIFO state
  logic [31:0]   rx_mem_q [DEPTH];
  logic [AW-1:0] rx_rd_q, rx_wr_q;
  logic [AW:0]   rx_cnt_q;
  // Outbound FIFO state
  logic [31:0]   tx_mem_q [DEPTH];
  logic [AW-1:0] tx_rd_q, tx_wr_q;
  logic [AW:0]   tx_cnt_q;

  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_push, rx_pop, tx_push, tx_pop;
  logic is_rd, is_wr;

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL);
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == FULL);

  // Decode the X-stage CSR access; only the two supported directions are legal.
  assign is_rd = csr_req_val && !csr_req_wen && (csr_req_addr == CSR_MNGR2PROC);
  assign is_wr = csr_req_val &&  csr_req_wen && (csr_req_addr == CSR_PROC2MNGR);

  // Handshake-side outputs depend on registered occupancy only (and reset).
  assign mngr2proc_rdy = !rst && !rx_full;
  assign proc2mngr_val = !rst && !tx_empty;
  assign proc2mngr_msg = proc2mngr_val ? tx_mem_q[tx_rd_q] : 32'h0;

  assign rx_push = mngr2proc_val && mngr2proc_rdy;
  assign tx_pop  = proc2mngr_val && proc2mngr_rdy;
  assign rx_pop  = !rst && is_rd && !rx_empty;
  assign tx_push = !rst && is_wr && !tx_full;

  // CSR response: stall on empty/full, illegal for anything else, quiet when idle.
  always_comb begin
    csr_req_stall   = 1'b0;
    csr_req_illegal = 1'b0;
    csr_resp_rdata  = 32'h0;
    if (!rst && csr_req_val) begin
      if (is_rd) begin
        csr_req_stall  = rx_empty;
        csr_resp_rdata = rx_empty ? 32'h0 : rx_mem_q[rx_rd_q];
      end else if (is_wr) begin
        csr_req_stall = tx_full;
      end else begin
        csr_req_illegal = 1'b1;
      end
    end
  end

  // Message storage: plain arrays, written on push, no reset needed.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wr_q] <= mngr2proc_msg;
    if (tx_push) tx_mem_q[tx_wr_q] <= csr_req_wdata;
  end

  // Inbound pointers and occupancy; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
      if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + ONE;
      else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - ONE;
    end
  end

  // Outbound pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_rd_q  <= '0;
      tx_wr_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + ONE;
      else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - ONE;
    end
  end

`ifdef PROC_MNGR_STATS_EN
  logic [15:0] rx_count_q, tx_count_q;
  assign rx_count = rx_count_q;
  assign tx_count = tx_count_q;

  // Handshake counters, free-running with natural 16-bit wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_count_q <= 16'h0;
      tx_count_q <= 16'h0;
    end else begin
      if (rx_push) rx_count_q <= rx_count_q + 16'h1;
      if (tx_pop)  tx_count_q <= tx_count_q + 16'h1;
    end
  end
`endif

endmodule

// File: tb/tb_proc_mngr_port.sv
// Testbench for proc_mngr_port: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_proc_mngr_port;
  localparam int DEPTH = 2;
  localparam logic [11:0] A_RX = 12'hFC0;
  localparam logic [11:0] A_TX = 12'h7C0;

  logic        clk = 1'b0;
  logic        rst;
  logic        mngr2proc_val, mngr2proc_rdy;
  logic [31:0] mngr2proc_msg;
  logic        proc2mngr_val, proc2mngr_rdy;
  logic [31:0] proc2mngr_msg;
  logic        csr_req_val, csr_req_wen;
  logic [11:0] csr_req_addr;
  logic [31:0] csr_req_wdata;
  logic        csr_req_stall, csr_req_illegal;
  logic [31:0] csr_resp_rdata;
`ifdef PROC_MNGR_STATS_EN
  logic [15:0] rx_count, tx_count;
  logic [15:0] m_rxc, m_txc;
`endif

  always #5 clk = ~clk;

  proc_mngr_port #(.DEPTH(DEPTH), .CSR_MNGR2PROC(A_RX), .CSR_PROC2MNGR(A_TX)) dut (
    .clk(clk), .rst(rst),
    .mngr2proc_val(mngr2proc_val), .mngr2proc_rdy(mngr2proc_rdy), .mngr2proc_msg(mngr2proc_msg),
    .proc2mngr_val(proc2mngr_val), .proc2mngr_rdy(proc2mngr_rdy), .proc2mngr_msg(proc2mngr_msg),
    .csr_req_val(csr_req_val), .csr_req_wen(csr_req_wen), .csr_req_addr(csr_req_addr),
    .csr_req_wdata(csr_req_wdata), .csr_req_stall(csr_req_stall),
    .csr_resp_rdata(csr_resp_rdata), .csr_req_illegal(csr_req_illegal)
`ifdef PROC_MNGR_STATS_EN
    , .rx_count(rx_count), .tx_count(tx_count)
`endif
  );

  // Reference model: message queues plus a log of delivered outbound messages.
  logic [31:0] rxq[$];
  logic [31:0] txq[$];
  logic [31:0] delivered[$];
  int nvec = 0;
  int nerr = 0;

  // Samples of DUT outputs taken mid-cycle by step(), used for literal checks.
  logic        s_rdy, s_val, s_stall, s_ill;
  logic [31:0] s_msg, s_rdata;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  // Apply one cycle of inputs, compare every output against the model, then
  // advance the model by what the clock edge must do.
  task automatic step(input logic r, input logic mv, input logic [31:0] mm, input logic pr,
                      input logic cv, input logic cw, input logic [11:0] ca, input logic [31:0] cd);
    logic rd, wr, e_rdy, e_val, e_stall, e_ill;
    logic [31:0] e_msg, e_rdata;
    rst = r; mngr2proc_val = mv; mngr2proc_msg = mm; proc2mngr_rdy = pr;
    csr_req_val = cv; csr_req_wen = cw; csr_req_addr = ca; csr_req_wdata = cd;
    #4;
    s_rdy = mngr2proc_rdy; s_val = proc2mngr_val; s_msg = proc2mngr_msg;
    s_stall = csr_req_stall; s_ill = csr_req_illegal; s_rdata = csr_resp_rdata;
    rd = cv && !cw && (ca == A_RX);
    wr = cv && cw && (ca == A_TX);
    if (r) begin
      e_rdy = 0; e_val = 0; e_msg = 0; e_stall = 0; e_ill = 0; e_rdata = 0;
    end else begin
      e_rdy   = rxq.size() < DEPTH;
      e_val   = txq.size() != 0;
      e_msg   = e_val ? txq[0] : 32'h0;
      e_ill   = cv && !rd && !wr;
      e_stall = (rd && rxq.size() == 0) || (wr && txq.size() == DEPTH);
      e_rdata = (rd && rxq.size() != 0) ? rxq[0] : 32'h0;
    end
    nvec++;
    chk("mngr2proc_rdy", {31'h0, s_rdy}, {31'h0, e_rdy});
    chk("proc2mngr_val", {31'h0, s_val}, {31'h0, e_val});
    chk("proc2mngr_msg", s_msg, e_msg);
    chk("csr_req_stall", {31'h0, s_stall}, {31'h0, e_stall});
    chk("csr_req_illegal", {31'h0, s_ill}, {31'h0, e_ill});
    chk("csr_resp_rdata", s_rdata, e_rdata);
`ifdef PROC_MNGR_STATS_EN
    if (!r) begin
      chk("rx_count", {16'h0, rx_count}, {16'h0, m_rxc});
      chk("tx_count", {16'h0, tx_count}, {16'h0, m_txc});
    end
`endif
    $display("cyc %0d rst=%b mv=%b mm=%h pr=%b cv=%b cw=%b ca=%h cd=%h | rdy=%b val=%b msg=%h stall=%b ill=%b rdata=%h",
             nvec, r, mv, mm, pr, cv, cw, ca, cd, s_rdy, s_val, s_msg, s_stall, s_ill, s_rdata);
    if (r) begin
      rxq.delete(); txq.delete();
`ifdef PROC_MNGR_STATS_EN
      m_rxc = 0; m_txc = 0;
`endif
    end else begin
      if (e_val && pr) begin
        delivered.push_back(txq.pop_front());
`ifdef PROC_MNGR_STATS_EN
        m_txc++;
`endif
      end
      if (wr && !e_stall) txq.push_back(cd);
      if (rd && !e_stall) void'(rxq.pop_front());
      if (mv && e_rdy) begin
        rxq.push_back(mm);
`ifdef PROC_MNGR_STATS_EN
        m_rxc++;
`endif
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic pr);
    step(0, 0, 0, pr, 0, 0, 0, 0);
  endtask

  initial begin
    int next, got, cyc;
    logic have;
    logic [31:0] hold;
`ifdef PROC_MNGR_STATS_EN
    m_rxc = 0; m_txc = 0;
`endif
    // Reset, then first cycle out of reset must accept.
    step(1, 1, 32'h55, 1, 1, 0, A_RX, 0);
    chk("rst_rdy", {31'h0, s_rdy}, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    chk("post_rst_rdy", {31'h0, s_rdy}, 32'h1);

    // Single message each way.
    step(0, 1, 32'h21, 0, 1, 0, A_RX, 0);
    chk("single_stall", {31'h0, s_stall}, 32'h1);
    step(0, 0, 0, 0, 1, 0, A_RX, 0);
    chk("single_rdata", s_rdata, 32'h21);
    chk("single_nostall", {31'h0, s_stall}, 32'h0);
    step(0, 0, 0, 0, 1, 1, A_TX, 32'h4B);
    idle(1);
    chk("single_val", {31'h0, s_val}, 32'h1);
    chk("single_msg", s_msg, 32'h4B);

    // Inbound full: 3 waits until a pop frees a slot.
    step(0, 1, 32'h1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h2, 0, 0, 0, 0, 0);
    step(0, 1, 32'h3, 0, 0, 0, 0, 0);
    chk("full_rdy", {31'h0, s_rdy}, 32'h0);
    step(0, 1, 32'h3, 0, 1, 0, A_RX, 0);
    chk("full_pop1", s_rdata, 32'h1);
    chk("full_rdy_ignores_pop", {31'h0, s_rdy}, 32'h0);
    step(0, 1, 32'h3, 0, 1, 0, A_RX, 0);
    chk("full_pop2", s_rdata, 32'h2);
    step(0, 0, 0, 0, 1, 0, A_RX, 0);
    chk("full_pop3", s_rdata, 32'h3);

    // Outbound backpressure.
    delivered.delete();
    step(0, 0, 0, 0, 1, 1, A_TX, 32'hA);
    step(0, 0, 0, 0, 1, 1, A_TX, 32'hB);
    step(0, 0, 0, 0, 1, 1, A_TX, 32'hC);
    chk("bp_stall3", {31'h0, s_stall}, 32'h1);
    step(0, 0, 0, 1, 1, 1, A_TX, 32'hC);
    chk("bp_stall_rdy", {31'h0, s_stall}, 32'h1);
    chk("bp_msgA", s_msg, 32'hA);
    step(0, 0, 0, 1, 1, 1, A_TX, 32'hC);
    chk("bp_msgB", s_msg, 32'hB);
    idle(1);
    chk("bp_msgC", s_msg, 32'hC);
    chk("bp_count", delivered.size(), 3);

    // Stream 0..15 through the core (csrr then csrw of the same value).
    delivered.delete();
    next = 0; have = 0; hold = 0; cyc = 0;
    while (delivered.size() < 16 && cyc < 300) begin
      logic mv_n, tk_rd, tk_wr;
      mv_n  = next < 16;
      tk_rd = !have && rxq.size() != 0;
      tk_wr = have && txq.size() < DEPTH;
      if (have) step(0, mv_n, next, 1, 1, 1, A_TX, hold);
      else      step(0, mv_n, next, 1, 1, 0, A_RX, 0);
      if (mv_n && s_rdy) next++;
      if (tk_rd) begin hold = s_rdata; have = 1; end
      else if (tk_wr) have = 0;
      cyc++;
    end
    chk("stream_count", delivered.size(), 16);
    for (int i = 0; i < 16 && i < delivered.size(); i++) chk("stream_order", delivered[i], i);

    // Illegal accesses leave occupancy untouched.
    step(0, 1, 32'h77, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, A_TX, 32'h88);
    step(0, 0, 0, 0, 1, 0, A_TX, 0);
    chk("ill_rd_ill", {31'h0, s_ill}, 32'h1);
    chk("ill_rd_stall", {31'h0, s_stall}, 32'h0);
    chk("ill_rd_rdata", s_rdata, 32'h0);
    step(0, 0, 0, 0, 1, 1, A_RX, 32'h99);
    chk("ill_wr_ill", {31'h0, s_ill}, 32'h1);
    step(0, 0, 0, 0, 1, 0, A_RX, 0);
    chk("ill_rx_kept", s_rdata, 32'h77);
    idle(0);
    chk("ill_tx_kept", s_msg, 32'h88);

    // Reset mid-operation with both FIFOs at two entries.
    step(0, 1, 32'h5, 0, 1, 1, A_TX, 32'h6);
    step(0, 1, 32'h7, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, A_RX, 0);
    chk("rst_mid_val", {31'h0, s_val}, 32'h0);
    chk("rst_mid_stall", {31'h0, s_stall}, 32'h1);
`ifdef PROC_MNGR_STATS_EN
    chk("rst_mid_rxc", {16'h0, rx_count}, 32'h0);
    chk("rst_mid_txc", {16'h0, tx_count}, 32'h0);
`endif

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      logic [11:0] ca;
      case ($urandom_range(0, 3))
        0, 1: ca = A_RX;
        2:    ca = A_TX;
        default: ca = 12'($urandom);
      endcase
      if ($urandom_range(0, 1)) ca = (ca == A_RX) ? A_TX : (ca == A_TX ? A_RX : ca);
      step($urandom_range(0, 99) == 0, 1'($urandom), $urandom, 1'($urandom),
           $urandom_range(0, 3) != 0, 1'($urandom), ca, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
